// File: rtl/l2_mem_arbiter_if.sv
// Refill/writeback bundle between the two cache refill paths, the miss arbiter and main memory.
// The master view belongs to the arbiter; the slave view is the cache/memory side.
interface l2_mem_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  i_req;
   logic [DATA_WIDTH-1:0] i_addr;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic                  i_ack;
   logic                  d_req;
   logic [DATA_WIDTH-1:0] d_addr;
   logic                  d_wb;
   logic [DATA_WIDTH-1:0] d_wb_addr;
   logic [DATA_WIDTH-1:0] d_wb_data;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic                  d_ack;
   logic                  mem_en;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  busy;

   modport master (
      input  i_req, i_addr, d_req, d_addr, d_wb, d_wb_addr, d_wb_data, mem_rdata,
      output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport slave (
      output i_req, i_addr, d_req, d_addr, d_wb, d_wb_addr, d_wb_data, mem_rdata,
      input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/l2_mem_arbiter.sv
// Miss controller: round-robin between I-side and D-side refills, optional dirty writeback,
// then a fixed-latency memory read and a one-cycle ack to the owner.
//
// state   | meaning
// IDLE    | waiting for a refill request; grant is taken at the clock edge
// WB      | single write of the latched D-side victim
// RD      | read strobe held MEM_LATENCY cycles; last cycle captures mem_rdata
// ACK     | one-cycle ack and refill word to the owner; round-robin pointer updated
module l2_mem_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 2
) (
   input logic                 clk,
   input logic                 rst,
   l2_mem_arbiter_if.master    bus
);

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WB,
      ST_RD,
      ST_ACK
   } state_t;

   state_t                state_q,   state_d;
   logic                  owner_d_q, owner_d_d;
   logic                  rr_d_q,    rr_d_d;
   logic [DATA_WIDTH-1:0] addr_q,    addr_d;
   logic [DATA_WIDTH-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
   logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
   logic [CW-1:0]         cnt_q,     cnt_d;
   logic                  grant_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         owner_d_q <= 1'b0;
         rr_d_q    <= 1'b0;
         addr_q    <= '0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         rdata_q   <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         owner_d_q <= owner_d_d;
         rr_d_q    <= rr_d_d;
         addr_q    <= addr_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d_d = owner_d_q;
      rr_d_d    = rr_d_q;
      addr_d    = addr_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      grant_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               // rr_d_q=0 means I went last, so D takes a tie
               grant_d   = bus.d_req && (!bus.i_req || !rr_d_q);
               owner_d_d = grant_d;
               addr_d    = grant_d ? bus.d_addr : bus.i_addr;
               wb_addr_d = bus.d_wb_addr;
               wb_data_d = bus.d_wb_data;
               cnt_d     = '0;
               state_d   = (grant_d && bus.d_wb) ? ST_WB : ST_RD;
            end
         end
         ST_WB: state_d = ST_RD;
         ST_RD: begin
            if (cnt_q == CNT_LAST) begin
               rdata_d = bus.mem_rdata;
               cnt_d   = '0;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ACK: begin
            rr_d_d  = owner_d_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.mem_en    = (state_q == ST_WB) || (state_q == ST_RD);
   assign bus.mem_we    = (state_q == ST_WB);
   assign bus.mem_addr  = (state_q == ST_WB) ? wb_addr_q :
                          (state_q == ST_RD) ? addr_q : '0;
   assign bus.mem_wdata = (state_q == ST_WB) ? wb_data_q : '0;
   assign bus.i_ack     = (state_q == ST_ACK) && !owner_d_q;
   assign bus.d_ack     = (state_q == ST_ACK) &&  owner_d_q;
   assign bus.i_rdata   = bus.i_ack ? rdata_q : '0;
   assign bus.d_rdata   = bus.d_ack ? rdata_q : '0;
   assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Bench for l2_mem_arbiter: transaction-level reference model feeds expectation queues,
// an independent negedge monitor pops and compares whatever the DUT presents.
module tb_l2_mem_arbiter;
   localparam int ML = 2;

   typedef struct {
      int          issue;
      logic [31:0] addr;
      bit          wb;
      logic [31:0] wb_addr;
      logic [31:0] wb_data;
   } req_t;

   typedef struct {
      int          cyc;
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } mem_ev_t;

   typedef struct {
      int          cyc;
      bit          side_d;
      logic [31:0] data;
   } ack_ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   l2_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

   l2_mem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(ML)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   req_t    pend_i[$], pend_d[$];
   mem_ev_t exp_mem[$];
   ack_ev_t exp_ack[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] bus_mem[logic [31:0]];
   int free_edge = 0, busy_from = 1, busy_to = 0;
   bit rr_last_d = 1'b0;

   function automatic logic [31:0] mem_init(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: one transaction at a time, next grant two cycles after the ack cycle.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         exp_mem.delete(); exp_ack.delete(); pend_i.delete(); pend_d.delete();
         free_edge = 0; busy_from = 1; busy_to = 0; rr_last_d = 1'b0;
      end else begin
         cyc++;
         if (cyc >= free_edge) begin
            bit hi, hd, sd;
            int w;
            req_t r;
            logic [31:0] rd;
            hi = (pend_i.size() > 0) && (pend_i[0].issue < cyc);
            hd = (pend_d.size() > 0) && (pend_d[0].issue < cyc);
            if (hi || hd) begin
               sd = hd && (!hi || !rr_last_d);
               r  = sd ? pend_d.pop_front() : pend_i.pop_front();
               w  = (sd && r.wb) ? 1 : 0;
               if (w == 1) begin
                  exp_mem.push_back('{cyc, 1'b1, r.wb_addr, r.wb_data});
                  ref_mem[r.wb_addr] = r.wb_data;
               end
               for (int k = 0; k < ML; k++)
                  exp_mem.push_back('{cyc + w + k, 1'b0, r.addr, 32'h0});
               rd = ref_mem.exists(r.addr) ? ref_mem[r.addr] : mem_init(r.addr);
               exp_ack.push_back('{cyc + w + ML, sd, rd});
               busy_from = cyc;
               busy_to   = cyc + w + ML;
               free_edge = cyc + w + ML + 2;
               rr_last_d = sd;
            end
         end
      end
   end

   // Memory responder: garbage until the read strobe has been held ML cycles.
   int rd_cnt = 0;
   logic [31:0] rd_addr = '0;
   initial forever begin
      @(negedge clk);
      if (bus.mem_en && bus.mem_we) begin
         bus_mem[bus.mem_addr] = bus.mem_wdata;
         rd_cnt = 0;
         bus.mem_rdata = $urandom;
      end else if (bus.mem_en) begin
         rd_cnt  = (rd_cnt > 0 && bus.mem_addr == rd_addr) ? rd_cnt + 1 : 1;
         rd_addr = bus.mem_addr;
         if (rd_cnt == ML)
            bus.mem_rdata = bus_mem.exists(rd_addr) ? bus_mem[rd_addr] : mem_init(rd_addr);
         else
            bus.mem_rdata = $urandom;
      end else begin
         rd_cnt = 0;
         bus.mem_rdata = $urandom;
      end
   end

   // Monitor
   initial forever begin
      mem_ev_t me;
      ack_ev_t ae;
      @(negedge clk);
      if (!rst) begin
         chk("busy", 32'(bus.busy), 32'(cyc >= busy_from && cyc <= busy_to));
         chk("ack_overlap", 32'(bus.i_ack & bus.d_ack), 32'h0);
         if (bus.mem_en) begin
            if (exp_mem.size() == 0) begin
               chk("mem_unexpected", 32'(bus.mem_en), 32'h0);
            end else begin
               me = exp_mem.pop_front();
               chk("mem_cycle", 32'(cyc), 32'(me.cyc));
               chk("mem_we", 32'(bus.mem_we), 32'(me.we));
               chk("mem_addr", bus.mem_addr, me.addr);
               if (me.we) chk("mem_wdata", bus.mem_wdata, me.data);
            end
         end
         if (bus.i_ack || bus.d_ack) begin
            if (exp_ack.size() == 0) begin
               chk("ack_unexpected", 32'(bus.i_ack | bus.d_ack), 32'h0);
            end else begin
               ae = exp_ack.pop_front();
               chk("ack_cycle", 32'(cyc), 32'(ae.cyc));
               chk("ack_side_d", 32'(bus.d_ack), 32'(ae.side_d));
               chk("ack_rdata", ae.side_d ? bus.d_rdata : bus.i_rdata, ae.data);
               chk("ack_other_rdata", ae.side_d ? bus.i_rdata : bus.d_rdata, 32'h0);
            end
         end else begin
            chk("i_rdata_idle", bus.i_rdata, 32'h0);
            chk("d_rdata_idle", bus.d_rdata, 32'h0);
         end
      end
   end

   // Raise a request (caller is at a negedge) and wait for its ack.
   task automatic run_req(input bit side_d, input logic [31:0] a, input bit wb,
                          input logic [31:0] wa, input logic [31:0] wd,
                          input bit hold, input bit mess);
      req_t r;
      bit got = 1'b0;
      r.issue = cyc; r.addr = a; r.wb = wb; r.wb_addr = wa; r.wb_data = wd;
      if (side_d) begin
         bus.d_req = 1'b1; bus.d_addr = a; bus.d_wb = wb; bus.d_wb_addr = wa; bus.d_wb_data = wd;
         pend_d.push_back(r);
      end else begin
         bus.i_req = 1'b1; bus.i_addr = a;
         pend_i.push_back(r);
      end
      for (int t = 0; t < 40 && !got; t++) begin
         @(negedge clk);
         got = side_d ? bus.d_ack : bus.i_ack;
         if (!got && mess && (side_d ? pend_d.size() == 0 : pend_i.size() == 0)) begin
            // in flight: field changes and a dropped req must not disturb the transfer
            if (side_d) begin
               bus.d_addr = $urandom; bus.d_wb = ~bus.d_wb;
               bus.d_wb_addr = $urandom; bus.d_wb_data = $urandom;
               if ($urandom_range(0, 3) == 0) bus.d_req = 1'b0;
            end else begin
               bus.i_addr = $urandom;
               if ($urandom_range(0, 3) == 0) bus.i_req = 1'b0;
            end
         end
      end
      if (!got) chk("ack_timeout", 32'(side_d), 32'(!side_d));
      if (!hold) begin
         if (side_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic rand_side(input bit side_d, input int n);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(1, 4)) @(negedge clk);
         run_req(side_d, 32'($urandom_range(0, 15) * 4), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 15) * 4), $urandom, 1'b0, 1'b1);
      end
   endtask

   initial begin
      bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_addr = 0;
      bus.d_wb = 0; bus.d_wb_addr = 0; bus.d_wb_data = 0; bus.mem_rdata = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("idle_busy", 32'(bus.busy), 32'h0);
         chk("idle_mem_en", 32'(bus.mem_en), 32'h0);
         chk("idle_acks", 32'({bus.i_ack, bus.d_ack}), 32'h0);
      end

      ref_mem[32'h40] = 32'hDEADBEEF; bus_mem[32'h40] = 32'hDEADBEEF;
      run_req(1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      ref_mem[32'h100] = 32'hCAFEF00D; bus_mem[32'h100] = 32'hCAFEF00D;
      run_req(1'b1, 32'h100, 1'b1, 32'h80, 32'h12345678, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      // Tie right after reset, then both held high: D, I, D, I
      do_reset();
      @(negedge clk);
      fork
         begin
            run_req(1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            run_req(1'b1, 32'h204, 1'b1, 32'h208, 32'hA5A5A5A5, 1'b0, 1'b0);
         end
         begin
            run_req(1'b0, 32'h300, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            run_req(1'b0, 32'h304, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
         end
      join
      repeat (2) @(negedge clk);

      // Reset in the first read cycle: no ack, then a fresh request completes
      bus.i_req = 1'b1; bus.i_addr = 32'h44;
      pend_i.push_back('{cyc, 32'h44, 1'b0, 32'h0, 32'h0});
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      bus.i_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_i_ack", 32'(bus.i_ack), 32'h0);
      end
      rst = 1'b0;
      @(negedge clk);
      run_req(1'b0, 32'h48, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      fork
         rand_side(1'b0, 60);
         rand_side(1'b1, 60);
      join

      repeat (10) @(negedge clk);
      chk("exp_mem_drained", 32'(exp_mem.size()), 32'h0);
      chk("exp_ack_drained", 32'(exp_ack.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
